// File: rtl/truth_table_sweeper.sv
// ============================================================================
// Module   : truth_table_sweeper
// Brief    : Sweeps a,b,c,d through 0000..1111, samples f per pattern and
//            scores the captured truth table against an expected mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sweeper #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  mismatch_cnt,
    output logic        pass
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]       pat_q, pat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      table_q, table_d;
    logic [4:0]       mm_q, mm_d;
    logic             pass_q, pass_d;

    logic             sample;
    logic             miss;
    logic [4:0]       mm_next;

    assign sample  = (state_q == S_RUN) && (hold_cnt_q == HOLD_LAST);
    assign miss    = sample && (f != expected[idx_q]);
    assign mm_next = mm_q + {4'd0, miss};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        pat_d      = pat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        table_d    = table_q;
        mm_d       = mm_q;
        pass_d     = pass_q;

        case (state_q)
            S_IDLE: begin
                pat_d  = 4'd0;
                busy_d = 1'b0;
                if (start) begin
                    state_d    = S_RUN;
                    idx_d      = 4'd0;
                    hold_cnt_d = '0;
                    table_d    = 16'd0;
                    mm_d       = 5'd0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                busy_d     = 1'b1;
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
                if (sample) begin
                    table_d[idx_q] = f;
                    mm_d           = mm_next;
                    hold_cnt_d     = '0;
                    if (idx_q == 4'd15) begin
                        // Pass uses the count that already includes pattern 15.
                        state_d = S_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pat_d   = 4'd0;
                        pass_d  = (mm_next == 5'd0);
                    end else begin
                        idx_d = idx_q + 4'd1;
                        pat_d = idx_q + 4'd1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                pat_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            hold_cnt_q <= '0;
            pat_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            table_q    <= 16'd0;
            mm_q       <= 5'd0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            pat_q      <= pat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            table_q    <= table_d;
            mm_q       <= mm_d;
            pass_q     <= pass_d;
        end
    end

    assign a            = pat_q[3];
    assign b            = pat_q[2];
    assign c            = pat_q[1];
    assign d            = pat_q[0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign table_out    = table_q;
    assign mismatch_cnt = mm_q;
    assign pass         = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
// Module   : tb_truth_table_sweeper
// Brief    : Directed bench for truth_table_sweeper (HOLD_CYCLES 4 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_sweeper;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] expected;
    logic        a, b, c, d, f;
    logic        busy, done, pass;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;
    logic [1:0]  fsel;

    logic        start1;
    logic        a1, b1, c1, d1, f1;
    logic        busy1, done1, pass1;
    logic [15:0] table1;
    logic [4:0]  mm1;

    int checks   = 0;
    int failures = 0;

    truth_table_sweeper #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
        .a(a), .b(b), .c(c), .d(d), .f(f),
        .busy(busy), .done(done), .table_out(table_out),
        .mismatch_cnt(mismatch_cnt), .pass(pass)
    );

    truth_table_sweeper #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(16'h6996),
        .a(a1), .b(b1), .c(c1), .d(d1), .f(f1),
        .busy(busy1), .done(done1), .table_out(table1),
        .mismatch_cnt(mm1), .pass(pass1)
    );

    // Function under test, selectable per scenario.
    always_comb begin
        case (fsel)
            2'd0:    f = a ^ b ^ c ^ d;
            2'd1:    f = a & b & c & d;
            default: f = a | b;
        endcase
    end
    assign f1 = a1 ^ b1 ^ c1 ^ d1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full H=4 sweep; perturb_at >= 0 pulses start during that pattern.
    task automatic do_sweep(input logic [1:0] sel, input logic [15:0] golden,
                            input logic [15:0] exp_tab, input logic [4:0] exp_mm,
                            input logic exp_pass, input int perturb_at);
        fsel     = sel;
        expected = golden;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            check("pattern", {28'd0, a, b, c, d}, k / 4);
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            if (k == 0) begin
                check("pass_cleared", pass, 0);
                check("mm_cleared", mismatch_cnt, 0);
            end
            if (k == 32) check("table_partial", table_out, exp_tab & 16'h00FF);
            start = (perturb_at >= 0 && k == perturb_at * 4);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", done, 1);
        check("busy_finish", busy, 0);
        check("pattern_finish", {28'd0, a, b, c, d}, 0);
        check("table_out", table_out, exp_tab);
        check("mismatch_cnt", mismatch_cnt, exp_mm);
        check("pass", pass, exp_pass);
        @(negedge clk);
        check("done_once", done, 0);
        check("busy_idle", busy, 0);
        check("table_hold", table_out, exp_tab);
        check("pass_hold", pass, exp_pass);
    endtask

    initial begin
        int pulses;
        int t0;
        int tlast;

        rst_n    = 1'b0;
        start    = 1'b0;
        start1   = 1'b0;
        expected = 16'h0000;
        fsel     = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_pattern", {28'd0, a, b, c, d}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_table", table_out, 0);
        check("rst_mm", mismatch_cnt, 0);
        check("rst_pass", pass, 0);
        rst_n = 1'b1;

        do_sweep(2'd0, 16'h6996, 16'h6996, 5'd0,  1'b1, -1);
        do_sweep(2'd1, 16'h8001, 16'h8000, 5'd1,  1'b0, -1);
        do_sweep(2'd2, 16'h000F, 16'hFFF0, 5'd16, 1'b0, -1);
        do_sweep(2'd0, 16'h6996, 16'h6996, 5'd0,  1'b1, 7);

        // Abort at pattern 9.
        fsel     = 2'd0;
        expected = 16'h6996;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (36) @(negedge clk);
        check("abort_pattern9", {28'd0, a, b, c, d}, 9);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_pattern", {28'd0, a, b, c, d}, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_table", table_out, 0);
        check("abort_mm", mismatch_cnt, 0);
        check("abort_pass", pass, 0);
        repeat (70) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        do_sweep(2'd0, 16'h6996, 16'h6996, 5'd0, 1'b1, -1);

        // HOLD_CYCLES=1 with start held high: done every 18 cycles.
        @(negedge clk);
        start1 = 1'b1;
        pulses = 0;
        t0     = 0;
        tlast  = 0;
        for (int n = 1; n <= 80 && pulses < 3; n++) begin
            @(negedge clk);
            if (done1) begin
                pulses++;
                if (pulses == 1) check("h1_first_done", n, 17);
                else             check("h1_done_period", n - tlast, 18);
                tlast = n;
                check("h1_table", table1, 16'h6996);
                check("h1_mm", mm1, 0);
                check("h1_pass", pass1, 1);
                check("h1_busy", busy1, 0);
            end
        end
        check("h1_done_count", pulses, 3);
        start1 = 1'b0;
        if (t0 != 0) check("h1_unused", t0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-sequencing stimulus and capture stage for 4-input combinational lab functions.
- Drives the exhaustive a,b,c,d pattern sweep 0000..1111 into the function under test and samples its output f for every pattern.
- Assembles the 16-entry truth table and compares it against an expected mask.
- Sits directly upstream of, and wraps around, the 4-input function block, replacing hand-written stimulus lists with a synthesizable sequencer.

Parameters:
- HOLD_CYCLES, 4: clock cycles each pattern is held before f is sampled; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- expected  input  16  golden truth table; bit i is the expected f for pattern i.
- a  output  1  stimulus MSB (pattern bit 3).
- b  output  1  stimulus bit 2.
- c  output  1  stimulus bit 1.
- d  output  1  stimulus LSB (pattern bit 0).
- f  input  1  combinational response of the function under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  16  captured truth table; bit i is f sampled for pattern i.
- mismatch_cnt  output  5  number of patterns where f differed from expected, 0..16.
- pass  output  1  high when the last completed sweep had mismatch_cnt == 0.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n; it takes effect only on a rising clk edge with rst_n=0.
- Reset values:
  - state=IDLE.
  - {a,b,c,d}=0000, busy=0, done=0.
  - table_out=0, mismatch_cnt=0, pass=0.
  - Internal idx=0, hold_cnt=0.
- All outputs are registered.
- States:
  - IDLE:
    - {a,b,c,d}=0000, busy=0.
    - On start=1: go to RUN next edge. Set idx=0, hold_cnt=0, table_out=0, mismatch_cnt=0; clear pass.
  - RUN:
    - busy=1; {a,b,c,d}={idx[3:0]}, a is the MSB.
    - Each cycle: hold_cnt++.
    - At the edge where hold_cnt==HOLD_CYCLES-1, all of the following happen together:
      - Sample f into table_out[idx].
      - If f!=expected[idx], mismatch_cnt++.
      - hold_cnt=0.
      - If idx==15, go to FINISH; otherwise idx++.
  - FINISH:
    - Lasts one cycle; done=1, busy=0.
    - pass=(mismatch_cnt==0), computed from the final count including the pattern-15 sample.
    - Then go to IDLE with {a,b,c,d}=0000.
- Latency:
  - start is sampled at edge E0.
  - Pattern 0 appears on a..d after E0.
  - Pattern i is driven for exactly HOLD_CYCLES cycles.
  - done pulses in the cycle after the 16th sample: 16*HOLD_CYCLES cycles after RUN entry.
- f is sampled on the last cycle of each pattern's hold window, so the combinational function has HOLD_CYCLES-1 full cycles plus one cycle of settling margin.
- Register retention:
  - table_out, mismatch_cnt and pass hold their values after FINISH until the next accepted start.
  - table_out bits above the current idx read 0 during RUN.
- start while in RUN or FINISH is ignored; there is no queuing.
- start held high continuously begins a new sweep each time IDLE is re-entered, i.e. one idle cycle between sweeps.
- expected is sampled per-pattern at each sample edge; it must be held stable for the whole sweep. Changes mid-sweep affect only later comparisons.
- mismatch_cnt saturates naturally at 16; 5 bits suffice, and no wrap is possible.
- rst_n=0 mid-sweep:
  - Aborts the sweep on that edge and returns to reset values.
  - No done pulse; pass=0.
- HOLD_CYCLES=1: one cycle per pattern and a sample every cycle; sweep length is 16 cycles.

Test Plan:
- Parity: reset, HOLD_CYCLES=4, f=a^b^c^d, expected=16'h6996, start pulse.
  - a..d step 0000..1111, 4 cycles each.
  - done pulses once, 64 cycles after RUN entry.
  - table_out=16'h6996, mismatch_cnt=0, pass=1.
- AND4 with wrong golden: f=a&b&c&d, expected=16'h8001.
  - table_out=16'h8000, mismatch_cnt=1, pass=0.
- Inverted golden: f=a|b, expected=16'h000F (inverse of 16'hFFF0).
  - table_out=16'hFFF0, mismatch_cnt=16, pass=0.
- Ignored start: during a sweep, pulse start at pattern 7.
  - idx continues 8..15 with no restart.
  - Exactly one done pulse; results are identical to an unperturbed run.
- Mid-sweep reset: assert rst_n=0 at pattern 9 for one edge.
  - Next cycle: a..d=0000, busy=0, done=0, table_out=0, mismatch_cnt=0, pass=0.
  - A subsequent start completes normally.
- HOLD_CYCLES=1 and back-to-back start held high:
  - Each sweep takes 16 RUN cycles, then 1 FINISH cycle, then 1 IDLE cycle.
  - done period is 18 cycles; table_out is stable between sweeps.
